duty_modulator: RTL
===================

DUTY_MODULATOR -- requirements
Module: duty_modulator

Interface
REQ-001 Parameter TRANS_NUM, default 249: transducer entries processed per frame (1..256).
REQ-002 Parameter MULT_LATENCY, default 3: fixed latency of the external multiplier, in cycles, from MULT_A/MULT_B to MULT_P.
REQ-003 CLK  in  1  single system clock; all logic SHALL be on the rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  one-cycle frame-start pulse.
REQ-006 MOD  in  8  modulation coefficient; sampled only on an accepted START.
REQ-007 DUTY_ADDR  out  8  read address to the duty BRAM.
REQ-008 DUTY_DATA  in  8  BRAM read data, valid 1 cycle after DUTY_ADDR.
REQ-009 MULT_A  out  8  multiplier operand A (duty).
REQ-010 MULT_B  out  9  multiplier operand B (MOD+1).
REQ-011 MULT_P  in  17  multiplier product.
REQ-012 DUTY_OUT  out  8  modulated duty.
REQ-013 DUTY_OUT_IDX  out  8  transducer index of DUTY_OUT.
REQ-014 DUTY_OUT_VALID  out  1  DUTY_OUT/DUTY_OUT_IDX qualifier.
REQ-015 BUSY  out  1  frame in progress.
REQ-016 DONE  out  1  one-cycle end-of-frame pulse.

Function
REQ-017 FSM states: IDLE, ISSUE, DRAIN; IDLE->ISSUE on START; ISSUE->DRAIN after address TRANS_NUM-1 is issued; DRAIN->IDLE in the cycle after the last DUTY_OUT_VALID.
REQ-018 START sampled high in IDLE at cycle t0 SHALL latch MOD into an internal register and enter ISSUE at t0+1.
REQ-019 START while not IDLE SHALL be ignored; MOD changes outside an accepted START SHALL have no effect.
REQ-020 In ISSUE, DUTY_ADDR SHALL equal k at cycle t0+1+k, k = 0..TRANS_NUM-1, then hold TRANS_NUM-1.
REQ-021 MULT_A SHALL be DUTY_DATA registered once (address k appears on MULT_A at t0+3+k); MULT_B SHALL be latched MOD+1, zero-extended to 9 bits, constant for the whole frame.
REQ-022 A valid/index shift register of depth 2+MULT_LATENCY SHALL track each issued address; MULT_P for index k is sampled at t0+3+MULT_LATENCY+k.
REQ-023 DUTY_OUT SHALL be MULT_P[15:8] registered (floor(duty*(MOD+1)/256)); MOD=255 passes duty unchanged; MOD=0 yields 0.
REQ-024 DUTY_OUT_VALID SHALL be high and DUTY_OUT_IDX = k at cycle t0+4+MULT_LATENCY+k (default t0+7+k), one beat per index, contiguous, in ascending order.
REQ-025 BUSY SHALL be high from t0+1 through the cycle of the last DUTY_OUT_VALID inclusive, low otherwise.
REQ-026 DONE SHALL pulse for exactly one cycle, coincident with DUTY_OUT_VALID for index TRANS_NUM-1.
REQ-027 A START in the cycle after DONE (state IDLE) SHALL be accepted; frames SHALL never overlap.
REQ-028 TRANS_NUM=1 SHALL produce ISSUE for one cycle, one output beat and DONE at t0+4+MULT_LATENCY.
REQ-029 When DUTY_OUT_VALID is low, DUTY_OUT and DUTY_OUT_IDX SHALL hold their last values.

Reset
REQ-030 RST high SHALL immediately force: state IDLE, DUTY_ADDR 0, MULT_A 0, MULT_B 0, DUTY_OUT 0, DUTY_OUT_IDX 0, DUTY_OUT_VALID 0, BUSY 0, DONE 0, latched MOD 0, valid pipeline cleared.
REQ-031 RST mid-frame SHALL abort the frame without a DONE pulse; MULT_P values arriving after reset release SHALL NOT produce DUTY_OUT_VALID.
REQ-032 START asserted during RST, or in the same cycle RST is released, SHALL be ignored.

Verification
REQ-033 TRANS_NUM=249, duty[k]=k, MOD=255, START at t0 -> outputs k=0..248 at t0+7..t0+255, DUTY_OUT=k, DONE at t0+255.
REQ-034 duty all 200, MOD=127 -> every DUTY_OUT=100; MOD=0 -> every DUTY_OUT=0; duty 255, MOD=254 -> 254.
REQ-035 Second START at t0+50 while BUSY -> ignored; exactly 249 beats, one DONE.
REQ-036 RST pulse at t0+100 -> all outputs 0 asynchronously, no further VALID and no DONE; new START after release -> full correct frame.
REQ-037 Back-to-back: START in the cycle after DONE, MOD changed 255->64 -> second frame DUTY_OUT = floor(k*65/256).
REQ-038 TRANS_NUM=1, MOD=255, duty[0]=37 -> single beat, DUTY_OUT=37, IDX=0, DONE at t0+7.

Source files
------------

// File: rtl/duty_modulator.sv
// Streams TRANS_NUM duty entries from a BRAM through an external multiplier
// and emits floor(duty*(MOD+1)/256) with its index, one beat per cycle.
module duty_modulator #(
  parameter int TRANS_NUM    = 249,
  parameter int MULT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  mod_i,
  output logic [7:0]  duty_addr_o,
  input  logic [7:0]  duty_data_i,
  output logic [7:0]  mult_a_o,
  output logic [8:0]  mult_b_o,
  input  logic [16:0] mult_p_i,
  output logic [7:0]  duty_out_o,
  output logic [7:0]  duty_out_idx_o,
  output logic        duty_out_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  // BRAM read (1) + operand register (1) + multiplier latency.
  localparam int         PIPE_DEPTH = MULT_LATENCY + 2;
  localparam logic [7:0] LAST_IDX   = 8'(TRANS_NUM - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                state_q;
  logic                  armed_q;
  logic [7:0]            addr_q;
  logic [7:0]            mult_a_q;
  logic [8:0]            mult_b_q;
  logic [PIPE_DEPTH-1:0] vld_q;
  logic [7:0]            idx_q [PIPE_DEPTH];
  logic [7:0]            duty_out_q;
  logic [7:0]            duty_out_idx_q;
  logic                  duty_out_valid_q;
  logic                  done_q;

  logic                  start_ok;
  logic                  issue_vld_d;
  logic [7:0]            product_d;

  // armed_q stays low for the first edge after reset release, so a START
  // held across the release is not taken.
  assign start_ok    = start_i && armed_q && (state_q == IDLE);
  assign issue_vld_d = (state_q == ISSUE);
  // Bit 16 can only be set by an out-of-range product; saturate if it ever is.
  assign product_d   = mult_p_i[16] ? 8'hFF : mult_p_i[15:8];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
    end else begin
      armed_q  <= 1'b1;
      mult_a_q <= duty_data_i;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q  <= ISSUE;
            addr_q   <= '0;
            mult_b_q <= {1'b0, mod_i} + 9'd1;
          end
        end
        ISSUE: begin
          if (addr_q == LAST_IDX) state_q <= DRAIN;
          else                    addr_q  <= addr_q + 8'd1;
        end
        DRAIN: begin
          if (done_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the index pipeline is reset along with the valid bits; it is a
  // handful of flops, and a clean reset keeps the held outputs defined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int j = 0; j < PIPE_DEPTH; j++) idx_q[j] <= '0;
    end else begin
      vld_q    <= {vld_q[PIPE_DEPTH-2:0], issue_vld_d};
      idx_q[0] <= addr_q;
      for (int j = 1; j < PIPE_DEPTH; j++) idx_q[j] <= idx_q[j-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_out_q       <= '0;
      duty_out_idx_q   <= '0;
      duty_out_valid_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      if (vld_q[PIPE_DEPTH-1]) begin
        duty_out_q     <= product_d;
        duty_out_idx_q <= idx_q[PIPE_DEPTH-1];
      end
      duty_out_valid_q <= vld_q[PIPE_DEPTH-1];
      done_q           <= vld_q[PIPE_DEPTH-1] && (idx_q[PIPE_DEPTH-1] == LAST_IDX);
    end
  end

  assign duty_addr_o      = addr_q;
  assign mult_a_o         = mult_a_q;
  assign mult_b_o         = mult_b_q;
  assign duty_out_o       = duty_out_q;
  assign duty_out_idx_o   = duty_out_idx_q;
  assign duty_out_valid_o = duty_out_valid_q;
  assign busy_o           = (state_q != IDLE);
  assign done_o           = done_q;

endmodule
